// File: rtl/seven_seg_pkg.sv
// Shared types and constants for the 7-segment scanner: segment table,
// blank pattern and the scan state encoding.
package seven_seg_pkg;

   // Active-low {g,f,e,d,c,b,a} patterns for hex digits 0..F.
   localparam logic [6:0] SEG_TABLE [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };

   // All segments off.
   localparam logic [6:0] SEG_BLANK = 7'h7F;

   typedef enum logic [1:0] {
      OFF,
      DRIVE,
      GUARD
   } scan_state_t;

endpackage

// File: rtl/hex_to_seg.sv
// Combinational nibble to active-low segment lookup.
module hex_to_seg
   import seven_seg_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg_n
);

   assign seg_n = SEG_TABLE[nibble];

endmodule

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed common-anode 7-segment scanner with double-buffered load
// port, per-digit dwell/guard timing and leading-zero suppression.
module seven_seg_scanner
   import seven_seg_pkg::*;
#(
   parameter int NUM_DIGITS   = 4,
   parameter int REFRESH_DIV  = 50000,
   parameter int GUARD_CYCLES = 2
)
(
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    enable,
   input  logic                    lz_en,
   input  logic                    load_valid,
   output logic                    load_ready,
   input  logic [4*NUM_DIGITS-1:0] load_value,
   input  logic [NUM_DIGITS-1:0]   load_dp,
   output logic [6:0]              seg_n,
   output logic                    dp_n,
   output logic [NUM_DIGITS-1:0]   an_n,
   output logic                    frame_done
);

   localparam int CNT_W = $clog2(REFRESH_DIV);
   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(REFRESH_DIV - GUARD_CYCLES - 1);
   localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(REFRESH_DIV - 1);
   localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

   scan_state_t             state, state_next;
   logic [CNT_W-1:0]        cnt, cnt_next;
   logic [IDX_W-1:0]        idx, idx_next;
   logic                    frame_end;

   logic [4*NUM_DIGITS-1:0] active_val, pend_val;
   logic [NUM_DIGITS-1:0]   active_dp, pend_dp;
   logic                    pend_full;
   logic                    accept, transfer;

   logic [NUM_DIGITS-1:0]   suppress;
   logic [3:0]              cur_nibble;
   logic                    cur_dp, cur_sup;
   logic [6:0]              cur_seg;

   assign accept   = load_valid && load_ready;
   assign transfer = pend_full && (frame_end || state == OFF);

   // Scan state, slot counter and digit index registers.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      if (rst) begin
         state <= OFF;
         cnt   <= '0;
         idx   <= '0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
         idx   <= idx_next;
      end
   end

   // Next-state logic: dwell in DRIVE, blank in GUARD, advance digit at slot end.
   always_comb begin
      // NOTE: every output of this block gets a default first so no path
      // leaves a variable unassigned, which would infer a latch.
      state_next = state;
      cnt_next   = cnt;
      idx_next   = idx;
      frame_end  = 1'b0;
      if (!enable) begin
         state_next = OFF;
         cnt_next   = '0;
         idx_next   = '0;
      end else begin
         case (state)
            OFF: begin
               state_next = DRIVE;
               cnt_next   = '0;
               idx_next   = '0;
            end
            DRIVE: begin
               cnt_next = cnt + CNT_W'(1);
               if (cnt == DRIVE_LAST) state_next = GUARD;
            end
            GUARD: begin
               if (cnt == SLOT_LAST) begin
                  cnt_next   = '0;
                  state_next = DRIVE;
                  if (idx == IDX_LAST) begin
                     idx_next  = '0;
                     frame_end = 1'b1;
                  end else begin
                     idx_next = idx + IDX_W'(1);
                  end
               end else begin
                  cnt_next = cnt + CNT_W'(1);
               end
            end
            default: state_next = OFF;
         endcase
      end
   end

   // Load handshake and pending-to-active transfer at frame boundaries.
   always_ff @(posedge clk) begin
      // NOTE: the display buffers are ordinary registers and are reset, since
      // a reset must discard any pending value and blank the active one.
      if (rst) begin
         pend_val   <= '0;
         pend_dp    <= '0;
         pend_full  <= 1'b0;
         active_val <= '0;
         active_dp  <= '0;
         load_ready <= 1'b1;
      end else begin
         if (accept) begin
            pend_val  <= load_value;
            pend_dp   <= load_dp;
            pend_full <= 1'b1;
         end else if (transfer) begin
            active_val <= pend_val;
            active_dp  <= pend_dp;
            pend_full  <= 1'b0;
         end
         // Ready returns one cycle after the transfer empties pending.
         load_ready <= !pend_full && !accept;
      end
   end

   // Leading-zero mask: a digit is blank if it and all higher digits are 0 without dp.
   always_comb begin
      logic zero_run;
      zero_run = 1'b1;
      suppress = '0;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         zero_run = zero_run && (active_val[4*i +: 4] == 4'h0) && !active_dp[i];
         if (i != 0) suppress[i] = lz_en && zero_run;
      end
   end

   // Select the nibble, dp and suppression flag of the digit being scanned.
   always_comb begin
      cur_nibble = 4'h0;
      cur_dp     = 1'b0;
      cur_sup    = 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (idx == IDX_W'(i)) begin
            cur_nibble = active_val[4*i +: 4];
            cur_dp     = active_dp[i];
            cur_sup    = suppress[i];
         end
      end
   end

   hex_to_seg u_hex_to_seg (
      .nibble (cur_nibble),
      .seg_n  (cur_seg)
   );

   // Registered pin drivers; blank immediately when enable drops.
   always_ff @(posedge clk) begin
      if (rst) begin
         seg_n      <= SEG_BLANK;
         dp_n       <= 1'b1;
         an_n       <= '1;
         frame_done <= 1'b0;
      end else begin
         frame_done <= frame_end;
         if (enable && state == DRIVE && !cur_sup) begin
            an_n  <= ~(NUM_DIGITS'(1) << idx);
            seg_n <= cur_seg;
            dp_n  <= ~cur_dp;
         end else begin
            an_n  <= '1;
            seg_n <= SEG_BLANK;
            dp_n  <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Self-checking bench for seven_seg_scanner: directed scenarios followed by
// randomized loads/enables, all compared against a frame-position model.
module tb_seven_seg_scanner;

   localparam int N     = 4;
   localparam int R     = 8;
   localparam int G     = 2;
   localparam int FRAME = N * R;

   logic        clk = 1'b0;
   logic        rst;
   logic        enable;
   logic        lz_en;
   logic        load_valid;
   logic        load_ready;
   logic [15:0] load_value;
   logic [3:0]  load_dp;
   logic [6:0]  seg_n;
   logic        dp_n;
   logic [3:0]  an_n;
   logic        frame_done;

   int checks = 0;
   int errors = 0;

   // Model: consecutive enable-high edges, handshake and buffer contents.
   int          m_run       = 0;
   int          m_pos       = -1;
   bit          m_ready     = 1'b1;
   bit          m_pend_full = 1'b0;
   logic [15:0] m_pend      = '0;
   logic [3:0]  m_pend_dp   = '0;
   logic [15:0] m_active    = '0;
   logic [3:0]  m_active_dp = '0;

   seven_seg_scanner #(
      .NUM_DIGITS   (N),
      .REFRESH_DIV  (R),
      .GUARD_CYCLES (G)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .enable     (enable),
      .lz_en      (lz_en),
      .load_valid (load_valid),
      .load_ready (load_ready),
      .load_value (load_value),
      .load_dp    (load_dp),
      .seg_n      (seg_n),
      .dp_n       (dp_n),
      .an_n       (an_n),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   function automatic logic [6:0] seg_of(input logic [3:0] h);
      case (h)
         4'h0: return 7'h40;  4'h1: return 7'h79;
         4'h2: return 7'h24;  4'h3: return 7'h30;
         4'h4: return 7'h19;  4'h5: return 7'h12;
         4'h6: return 7'h02;  4'h7: return 7'h78;
         4'h8: return 7'h00;  4'h9: return 7'h10;
         4'hA: return 7'h08;  4'hB: return 7'h03;
         4'hC: return 7'h46;  4'hD: return 7'h21;
         4'hE: return 7'h06;  default: return 7'h0E;
      endcase
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // One clock edge: advance the model from the inputs presented, then compare.
   task automatic step();
      bit          en_s, lz_s, lv_s, rst_s, was_off, acc, xfer, ready_next, care;
      logic [15:0] val_s, old_val;
      logic [3:0]  dp_s, old_dp, exp_an;
      logic [6:0]  exp_seg;
      logic        exp_dp;
      int          new_p, d, w;
      en_s    = enable;
      lz_s    = lz_en;
      lv_s    = load_valid;
      rst_s   = rst;
      val_s   = load_value;
      dp_s    = load_dp;
      old_val = m_active;
      old_dp  = m_active_dp;
      was_off = (m_run == 0);
      @(posedge clk);
      if (rst_s) begin
         m_run       = 0;
         m_ready     = 1'b1;
         m_pend_full = 1'b0;
         m_pend      = '0;
         m_pend_dp   = '0;
         m_active    = '0;
         m_active_dp = '0;
         new_p       = -1;
      end else begin
         m_run = en_s ? m_run + 1 : 0;
         if (m_run >= 2 + FRAME) m_run -= FRAME;
         new_p      = (m_run >= 2) ? (m_run - 2) % FRAME : -1;
         acc        = lv_s && m_ready;
         xfer       = m_pend_full && (was_off || new_p == FRAME - 1);
         ready_next = !(m_pend_full || acc);
         if (acc) begin
            m_pend      = val_s;
            m_pend_dp   = dp_s;
            m_pend_full = 1'b1;
         end
         if (xfer) begin
            m_active    = m_pend;
            m_active_dp = m_pend_dp;
            m_pend_full = 1'b0;
         end
         m_ready = ready_next;
      end
      m_pos = new_p;

      exp_an  = 4'hF;
      exp_seg = 7'h7F;
      exp_dp  = 1'b1;
      care    = 1'b1;
      if (new_p >= 0) begin
         d = new_p / R;
         w = new_p % R;
         if (w < R - G) begin
            if (lz_s && d != 0 && (old_val >> (4 * d)) == 16'h0 && (old_dp >> d) == 4'h0) begin
               care = 1'b0;
            end else begin
               exp_an[d] = 1'b0;
               exp_seg   = seg_of(old_val[4*d +: 4]);
               exp_dp    = ~old_dp[d];
            end
         end
      end

      #1;
      check("an_n", 32'(an_n), 32'(exp_an));
      if (care) begin
         check("seg_n", 32'(seg_n), 32'(exp_seg));
         check("dp_n", 32'(dp_n), 32'(exp_dp));
      end
      check("frame_done", 32'(frame_done), 32'(new_p == FRAME - 1));
      check("load_ready", 32'(load_ready), 32'(m_ready));
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   // Offer a value on the load port and hold it until the handshake takes it.
   task automatic do_load(input logic [15:0] v, input logic [3:0] d);
      bit taken;
      taken      = 1'b0;
      load_valid = 1'b1;
      load_value = v;
      load_dp    = d;
      for (int i = 0; i < 4 * FRAME && !taken; i++) begin
         taken = m_ready;
         step();
      end
      load_valid = 1'b0;
      check("load_accept", 32'(taken), 32'(1));
   endtask

   task automatic wait_pos(input int target);
      for (int i = 0; i < 2 * FRAME && m_pos != target; i++) step();
      check("wait_pos", 32'(m_pos), 32'(target));
   endtask

   initial begin
      bit          will_acc;
      logic [15:0] rv;
      rst        = 1'b1;
      enable     = 1'b0;
      lz_en      = 1'b0;
      load_valid = 1'b0;
      load_value = '0;
      load_dp    = '0;

      // Reset values.
      step();
      rst = 1'b0;
      run(2);

      // Basic scan of 12AF.
      do_load(16'h12AF, 4'h0);
      enable = 1'b1;
      run(70);

      // Leading-zero suppression cases.
      lz_en = 1'b1;
      do_load(16'h0005, 4'h0);
      run(40);
      do_load(16'h0000, 4'h0);
      run(40);
      do_load(16'h0005, 4'b0100);
      run(40);

      // Load mid-frame during digit 1.
      lz_en = 1'b0;
      wait_pos(R);
      do_load(16'h3333, 4'h0);
      run(40);

      // Second load held while ready is low.
      do_load(16'hABCD, 4'b0001);
      do_load(16'h5678, 4'b1000);
      run(70);

      // Disable mid-DRIVE of digit 2, then re-enable.
      wait_pos(2 * R + 2);
      enable = 1'b0;
      run(5);
      enable = 1'b1;
      run(20);

      // Reset mid-frame with a pending value.
      wait_pos(5);
      load_valid = 1'b1;
      load_value = 16'hFFFF;
      load_dp    = 4'hF;
      step();
      load_valid = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      run(40);

      // Randomized loads, enable toggles, lz changes and resets.
      for (int c = 0; c < 2000; c++) begin
         if ($urandom_range(0, 199) == 0) enable = ~enable;
         if ($urandom_range(0, 99) == 0) lz_en = $urandom_range(0, 1) == 1;
         rst = ($urandom_range(0, 499) == 0);
         if (!load_valid && $urandom_range(0, 19) == 0) begin
            rv         = 16'($urandom);
            rv         = rv >> (4 * $urandom_range(0, 4));
            load_value = rv;
            load_dp    = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 15)) : 4'h0;
            load_valid = 1'b1;
         end
         will_acc = load_valid && m_ready && !rst;
         step();
         if (will_acc) load_valid = 1'b0;
      end
      rst = 1'b0;
      run(5);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
